mvm_result_packer: RTL and testbench
====================================

Name: mvm_result_packer

Overview:
- Downstream stage of the 3x3 matrix-vector multiply-add (MVMA) unit.
- Consumes the MVMA serial stream of signed 16-bit results and per-result overflow flags.
- Groups every K consecutive results into one output vector and optionally saturates overflowed elements.
- Buffers completed vectors in a small FIFO, presented on a valid/ready master port to the memory/writeback stage.

Parameters:
- K, 3, elements per output vector (matches the MVMA dimension).
- WIDTH, 16, bits per element (signed).
- DEPTH, 4, FIFO depth in vectors (power of 2, >=2).
- LOGDEPTH, 2, log2(DEPTH).

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- s_valid  input  1  upstream result valid.
- s_ready  output  1  packer can accept a result.
- data_in  input  WIDTH  signed result from MVMA.
- ovf_in  input  1  overflow flag qualifying data_in.
- m_valid  output  1  head vector valid.
- m_ready  input  1  downstream accepts head vector.
- data_out  output  K*WIDTH  packed vector; element 0 in bits [WIDTH-1:0].
- ovf_out  output  K  per-element overflow flags of head vector; bit i pairs with element i.
- ovf_count  output  8  count of accepted vectors with any overflow; saturates at 255.

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high on reset.
- Reset: elem_idx=0, FIFO empty, m_valid=0, ovf_count=0, row buffer cleared. s_ready comes up 1 once elem_idx=0 and the FIFO is not full. data_out and ovf_out are don't-care while m_valid=0. Reset mid-vector discards the partial row and all queued vectors.
- Accept: a result is accepted on a rising edge with s_valid && s_ready. data_in is ignored when s_valid=0, and may be X.
- Row assembly:
  - elem_idx (0..K-1) selects the row-buffer slot.
  - On accept with elem_idx<K-1: write the slot, then elem_idx++.
  - On accept with elem_idx==K-1: push the completed row (buffer plus the current element) into the FIFO on the same edge, then elem_idx wraps to 0.
- s_ready = !(elem_idx==K-1 && fifo_full). It is registered-state only, with no combinational path from m_ready. Partial rows are still accepted while the FIFO is full.
- Output side:
  - m_valid = !fifo_empty.
  - data_out/ovf_out show the FIFO head.
  - Pop on m_valid && m_ready.
  - Head is stable while m_valid && !m_ready.
- Simultaneous push and pop when full: not possible, because s_ready=0 on the last element. Push and pop in the same cycle otherwise: count unchanged, pointers both advance.
- Latency: last element accepted at edge N, FIFO empty → m_valid=1 in the cycle after edge N.
- ovf_count: increments by 1 at the push edge if any element of the pushed row has its overflow flag set. Holds at 255.
- Arithmetic: no arithmetic beyond saturation. Elements are stored as WIDTH-bit two's complement.
- Pointers: FIFO pointers are LOGDEPTH bits and wrap naturally. Occupancy is a (LOGDEPTH+1)-bit counter.

Optional Feature:
- Macro: MVM_PACK_SATURATE_EN.
- Defined: an element accepted with ovf_in=1 is replaced before storage.
  - If data_in[WIDTH-1]=1 (wrapped negative, true value positive), store +(2^(WIDTH-1)-1), i.e. 32767.
  - Otherwise store -2^(WIDTH-1), i.e. -32768.
  - The element's ovf_out bit is still 1.
- Undefined: data_in is stored unchanged (wrapped value). ovf_out and ovf_count behave identically.

Test Plan:
- Basic packing: reset, stream 15,34,53 with ovf_in=0, m_ready=1 → one vector: data_out elements {0:15, 1:34, 2:53}, ovf_out=3'b000, m_valid for exactly 1 cycle, ovf_count=0.
- Saturation, macro defined: stream -32763(ovf=1), 1205, 1998 → elements {32767, 1205, 1998}, ovf_out=3'b001, ovf_count=1. Macro undefined → element 0 = -32763, same flags.
- Backpressure/full: m_ready=0, stream 5 vectors (15 results) → 4 vectors queued. s_ready drops to 0 only when elem_idx=2 for the 5th vector. Raise m_ready → 5 vectors drain in order with values intact.
- Throughput: s_valid=1, m_ready=1 continuously for 30 results → 10 vectors out, with no gaps from the packer beyond K-1 cycles per vector.
- Mid-operation reset: accept 2 elements of a vector with 2 vectors queued, assert reset 1 cycle → m_valid=0, ovf_count=0. The next 3 results form a fresh vector at element 0.
- Random valid/ready: randomized s_valid/m_ready for 150 results → output stream equals reference grouping. No data accepted while s_valid=0, even with X on data_in.

Source files
------------

// File: rtl/mvm_result_packer_if.sv
`default_nettype none
// ============================================================================
//  Module      : mvm_result_packer_if
//  Description : Stream bundle around the MVMA result packer. The upstream
//                result stream (s_*, data_in, ovf_in) and the downstream
//                vector port (m_*, data_out, ovf_out, ovf_count) are carried
//                together. The 'slave' modport is the packer's view. The
//                'master' modport is the surrounding environment's view.
//  Revision    : 1.0  initial release
// ============================================================================
interface mvm_result_packer_if #(
    parameter int K     = 3,
    parameter int WIDTH = 16
);
    logic                 s_valid;
    logic                 s_ready;
    logic [WIDTH-1:0]     data_in;
    logic                 ovf_in;
    logic                 m_valid;
    logic                 m_ready;
    logic [K*WIDTH-1:0]   data_out;
    logic [K-1:0]         ovf_out;
    logic [7:0]           ovf_count;

    modport slave (
        input  s_valid, data_in, ovf_in, m_ready,
        output s_ready, m_valid, data_out, ovf_out, ovf_count
    );

    modport master (
        output s_valid, data_in, ovf_in, m_ready,
        input  s_ready, m_valid, data_out, ovf_out, ovf_count
    );
endinterface
`default_nettype wire

// File: rtl/mvm_result_packer.sv
`default_nettype none
// ============================================================================
//  Module      : mvm_result_packer
//  Description : Groups every K serial MVMA results into one packed vector.
//                Completed vectors are queued in a DEPTH-entry FIFO and then
//                presented on a valid/ready port. Element 0 occupies the LSBs.
//                Optional macro MVM_PACK_SATURATE_EN replaces each overflowed
//                element with the saturated value of the correct sign.
//  Revision    : 1.0  initial release
// ============================================================================
module mvm_result_packer #(
    parameter int K        = 3,
    parameter int WIDTH    = 16,
    parameter int DEPTH    = 4,
    parameter int LOGDEPTH = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    mvm_result_packer_if.slave    bus
);

    localparam int c_IDX_W = (K > 1) ? $clog2(K) : 1;

    // Row assembly state: slots 0..K-2 are buffered. The last element goes
    // straight into the FIFO together with the buffered slots.
    logic [c_IDX_W-1:0]   r_elem_idx;
    logic [WIDTH-1:0]     r_row_data [0:K-2];
    logic [K-2:0]         r_row_ovf;

    // Vector FIFO
    logic [K*WIDTH-1:0]   r_fifo_data [0:DEPTH-1];
    logic [K-1:0]         r_fifo_ovf  [0:DEPTH-1];
    logic [LOGDEPTH-1:0]  r_wr_ptr;
    logic [LOGDEPTH-1:0]  r_rd_ptr;
    logic [LOGDEPTH:0]    r_count;
    logic [7:0]           r_ovf_count;

    logic                 w_full;
    logic                 w_empty;
    logic                 w_last;
    logic                 w_s_ready;
    logic                 w_accept;
    logic                 w_push;
    logic                 w_pop;
    logic [WIDTH-1:0]     w_elem;
    logic [K*WIDTH-1:0]   w_push_data;
    logic [K-1:0]         w_push_ovf;

    assign w_full    = (r_count == (LOGDEPTH+1)'(DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_last    = (r_elem_idx == c_IDX_W'(K-1));
    // Only the row-completing element needs FIFO space; partial rows keep
    // flowing into the row buffer while the FIFO is full.
    assign w_s_ready = !(w_last && w_full);
    assign w_accept  = bus.s_valid && w_s_ready;
    assign w_push    = w_accept && w_last;
    assign w_pop     = !w_empty && bus.m_ready;

    // Element value to store: wrapped value, or the saturated value when enabled
    always_comb begin
        w_elem = bus.data_in;
`ifdef MVM_PACK_SATURATE_EN
        if (bus.ovf_in) begin
            // A negative wrapped result means the true value overflowed positive
            w_elem = bus.data_in[WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}}
                                          : {1'b1, {(WIDTH-1){1'b0}}};
        end
`endif
    end

    // Completed row: buffered slots plus the element arriving this cycle
    always_comb begin
        w_push_data = '0;
        for (int i = 0; i < K-1; i++) begin
            w_push_data[i*WIDTH +: WIDTH] = r_row_data[i];
        end
        w_push_data[(K-1)*WIDTH +: WIDTH] = w_elem;
        w_push_ovf = {bus.ovf_in, r_row_ovf};
    end

    // Control state: element index, row buffer, FIFO pointers, occupancy, overflow counter
    always_ff @(posedge clk) begin
        if (reset) begin
            r_elem_idx  <= '0;
            r_row_ovf   <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_ovf_count <= '0;
            for (int i = 0; i < K-1; i++) begin
                r_row_data[i] <= '0;
            end
        end else begin
            if (w_accept) begin
                if (w_last) begin
                    r_elem_idx <= '0;
                end else begin
                    r_elem_idx <= r_elem_idx + c_IDX_W'(1);
                    for (int i = 0; i < K-1; i++) begin
                        if (r_elem_idx == c_IDX_W'(i)) begin
                            r_row_data[i] <= w_elem;
                            r_row_ovf[i]  <= bus.ovf_in;
                        end
                    end
                end
            end

            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + LOGDEPTH'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + LOGDEPTH'(1);
            end

            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (LOGDEPTH+1)'(1);
                2'b01:   r_count <= r_count - (LOGDEPTH+1)'(1);
                default: r_count <= r_count;
            endcase

            if (w_push && (|w_push_ovf) && (r_ovf_count != 8'hFF)) begin
                r_ovf_count <= r_ovf_count + 8'd1;
            end
        end
    end

    // FIFO storage; contents are qualified by the occupancy counter, so no reset
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_data[r_wr_ptr] <= w_push_data;
            r_fifo_ovf[r_wr_ptr]  <= w_push_ovf;
        end
    end

    assign bus.s_ready   = w_s_ready;
    assign bus.m_valid   = !w_empty;
    assign bus.data_out  = r_fifo_data[r_rd_ptr];
    assign bus.ovf_out   = r_fifo_ovf[r_rd_ptr];
    assign bus.ovf_count = r_ovf_count;

endmodule
`default_nettype wire

// File: tb/tb_mvm_result_packer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mvm_result_packer
//  Description : Directed and randomised bench for mvm_result_packer.
//                The expected value of element 0 in the saturation case
//                depends on whether MVM_PACK_SATURATE_EN is defined.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_mvm_result_packer;

    localparam int K  = 3;
    localparam int W  = 16;
    localparam int VW = K*W + K;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    logic [VW-1:0] got [$];
    int            valid_cycles = 0;

    always #5 clk = ~clk;

    mvm_result_packer_if #(.K(K), .WIDTH(W)) bus ();

    mvm_result_packer #(.K(K), .WIDTH(W), .DEPTH(4), .LOGDEPTH(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Output monitor: a vector is taken at the next rising edge when valid && ready
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            if (bus.m_valid === 1'b1) valid_cycles++;
            if (bus.m_valid === 1'b1 && bus.m_ready === 1'b1)
                got.push_back({bus.ovf_out, bus.data_out});
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [VW-1:0] mkvec(input logic [W-1:0] e0, input logic [W-1:0] e1,
                                            input logic [W-1:0] e2, input logic [K-1:0] o);
        return {o, e2, e1, e0};
    endfunction

    // Stored value of an element under the active build option
    function automatic logic [W-1:0] exp_elem(input logic [W-1:0] d, input logic o);
`ifdef MVM_PACK_SATURATE_EN
        if (o) return d[W-1] ? 16'h7FFF : 16'h8000;
`endif
        return d;
    endfunction

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.s_valid = 1'b0;
        bus.data_in = 'x;
        bus.ovf_in  = 1'bx;
    endtask

    // Present one result and hold it until accepted; returns cycles spent waiting
    task automatic send(input logic [W-1:0] d, input logic o, output int waited);
        waited = 0;
        bus.s_valid = 1'b1;
        bus.data_in = d;
        bus.ovf_in  = o;
        @(negedge clk);
        while (bus.s_ready !== 1'b1 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 50) begin
            checks++; errors++;
            $display("FAIL send_timeout: s_ready stuck at %b, required 1", bus.s_ready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        cycles(1);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle();
        bus.m_ready = 1'b0;
        cycles(2);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid: got %b required 0", bus.m_valid); end
        checks++;
        if (bus.s_ready !== 1'b1) begin errors++; $display("FAIL reset_s_ready: got %b required 1", bus.s_ready); end
        checks++;
        if (bus.ovf_count !== 8'd0) begin errors++; $display("FAIL reset_ovf_count: got %0d required 0", bus.ovf_count); end
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        int base, vbase, w;
        base = got.size(); vbase = valid_cycles;
        bus.m_ready = 1'b1;
        send(16'd15, 1'b0, w);
        send(16'd34, 1'b0, w);
        send(16'd53, 1'b0, w);
        idle();
        @(negedge clk);
        checks++;
        if (bus.m_valid !== 1'b1) begin errors++; $display("FAIL basic_latency: m_valid %b required 1", bus.m_valid); end
        cycles(5);
        checks++;
        if (got.size() - base != 1) begin
            errors++; $display("FAIL basic_count: got %0d vectors required 1", got.size() - base);
        end else begin
            checks++;
            if (got[base] !== mkvec(16'd15, 16'd34, 16'd53, 3'b000)) begin
                errors++; $display("FAIL basic_vec: got %h required %h", got[base], mkvec(16'd15, 16'd34, 16'd53, 3'b000));
            end
        end
        checks++;
        if (valid_cycles - vbase != 1) begin errors++; $display("FAIL basic_valid_cycles: got %0d required 1", valid_cycles - vbase); end
        checks++;
        if (bus.ovf_count !== 8'd0) begin errors++; $display("FAIL basic_ovf_count: got %0d required 0", bus.ovf_count); end
    endtask

    task automatic test_saturation();
        int base, w;
        logic [VW-1:0] exp;
`ifdef MVM_PACK_SATURATE_EN
        exp = mkvec(16'h7FFF, 16'd1205, 16'd1998, 3'b001);
`else
        exp = mkvec(16'h8005, 16'd1205, 16'd1998, 3'b001);
`endif
        base = got.size();
        bus.m_ready = 1'b1;
        send(16'h8005, 1'b1, w);   // -32763 with overflow
        send(16'd1205, 1'b0, w);
        send(16'd1998, 1'b0, w);
        idle();
        cycles(4);
        checks++;
        if (got.size() - base != 1) begin
            errors++; $display("FAIL sat_count: got %0d vectors required 1", got.size() - base);
        end else begin
            checks++;
            if (got[base] !== exp) begin errors++; $display("FAIL sat_vec: got %h required %h", got[base], exp); end
        end
        checks++;
        if (bus.ovf_count !== 8'd1) begin errors++; $display("FAIL sat_ovf_count: got %0d required 1", bus.ovf_count); end
    endtask

    task automatic test_backpressure();
        int base, w, totw;
        logic [W-1:0] v [15];
        for (int i = 0; i < 15; i++) v[i] = 16'(1000 + 10*(i/3) + (i%3));
        do_reset();
        base = got.size();
        bus.m_ready = 1'b0;
        totw = 0;
        for (int i = 0; i < 14; i++) begin
            send(v[i], 1'b0, w);
            totw += w;
        end
        checks++;
        if (totw != 0) begin errors++; $display("FAIL bp_early_stall: waited %0d cycles required 0", totw); end
        bus.s_valid = 1'b1; bus.data_in = v[14]; bus.ovf_in = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.s_ready !== 1'b0) begin errors++; $display("FAIL bp_s_ready_full: got %b required 0", bus.s_ready); end
        checks++;
        if (bus.data_out !== {v[2], v[1], v[0]}) begin
            errors++; $display("FAIL bp_head: got %h required %h", bus.data_out, {v[2], v[1], v[0]});
        end
        checks++;
        if (got.size() != base) begin errors++; $display("FAIL bp_no_pop: got %0d vectors required 0", got.size() - base); end
        @(posedge clk); #1;
        bus.m_ready = 1'b1;
        send(v[14], 1'b0, w);
        idle();
        cycles(10);
        checks++;
        if (got.size() - base != 5) begin
            errors++; $display("FAIL bp_count: got %0d vectors required 5", got.size() - base);
        end else begin
            for (int j = 0; j < 5; j++) begin
                checks++;
                if (got[base+j] !== mkvec(v[3*j], v[3*j+1], v[3*j+2], 3'b000)) begin
                    errors++; $display("FAIL bp_vec%0d: got %h required %h", j, got[base+j], mkvec(v[3*j], v[3*j+1], v[3*j+2], 3'b000));
                end
            end
        end
    endtask

    task automatic test_throughput();
        int base, vbase, w, totw;
        logic [W-1:0] d [30];
        logic         o [30];
        do_reset();
        base = got.size(); vbase = valid_cycles;
        bus.m_ready = 1'b1;
        totw = 0;
        for (int i = 0; i < 30; i++) begin
            d[i] = 16'(i*7 - 100);
            o[i] = (i == 4 || i == 20);
            send(d[i], o[i], w);
            totw += w;
        end
        idle();
        cycles(5);
        checks++;
        if (totw != 0) begin errors++; $display("FAIL tp_stall: waited %0d cycles required 0", totw); end
        checks++;
        if (valid_cycles - vbase != 10) begin errors++; $display("FAIL tp_valid_cycles: got %0d required 10", valid_cycles - vbase); end
        checks++;
        if (bus.ovf_count !== 8'd2) begin errors++; $display("FAIL tp_ovf_count: got %0d required 2", bus.ovf_count); end
        checks++;
        if (got.size() - base != 10) begin
            errors++; $display("FAIL tp_count: got %0d vectors required 10", got.size() - base);
        end else begin
            for (int j = 0; j < 10; j++) begin
                logic [VW-1:0] e;
                e = mkvec(exp_elem(d[3*j], o[3*j]), exp_elem(d[3*j+1], o[3*j+1]),
                          exp_elem(d[3*j+2], o[3*j+2]), {o[3*j+2], o[3*j+1], o[3*j]});
                checks++;
                if (got[base+j] !== e) begin errors++; $display("FAIL tp_vec%0d: got %h required %h", j, got[base+j], e); end
            end
        end
    endtask

    task automatic test_mid_reset();
        int base, w;
        do_reset();
        bus.m_ready = 1'b0;
        for (int i = 0; i < 8; i++) send(16'(200 + i), (i == 1), w);
        idle();
        @(negedge clk);
        checks++;
        if (bus.ovf_count !== 8'd1) begin errors++; $display("FAIL mr_pre_ovf_count: got %0d required 1", bus.ovf_count); end
        checks++;
        if (bus.m_valid !== 1'b1) begin errors++; $display("FAIL mr_pre_m_valid: got %b required 1", bus.m_valid); end
        @(posedge clk); #1;
        reset = 1'b1;
        cycles(1);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.m_valid !== 1'b0) begin errors++; $display("FAIL mr_m_valid: got %b required 0", bus.m_valid); end
        checks++;
        if (bus.ovf_count !== 8'd0) begin errors++; $display("FAIL mr_ovf_count: got %0d required 0", bus.ovf_count); end
        @(posedge clk); #1;
        base = got.size();
        bus.m_ready = 1'b1;
        send(16'd77, 1'b0, w);
        send(16'd88, 1'b0, w);
        send(16'd99, 1'b0, w);
        idle();
        cycles(4);
        checks++;
        if (got.size() - base != 1) begin
            errors++; $display("FAIL mr_count: got %0d vectors required 1", got.size() - base);
        end else begin
            checks++;
            if (got[base] !== mkvec(16'd77, 16'd88, 16'd99, 3'b000)) begin
                errors++; $display("FAIL mr_vec: got %h required %h", got[base], mkvec(16'd77, 16'd88, 16'd99, 3'b000));
            end
        end
    endtask

    task automatic test_random();
        int base, nov, w;
        logic done;
        logic [VW-1:0] exp_q [$];
        logic [W-1:0]  d [3];
        logic          o [3];
        do_reset();
        base = got.size();
        nov  = 0;
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 150; i++) begin
                    idle();
                    cycles($urandom_range(0, 2));
                    d[i%3] = 16'($urandom);
                    o[i%3] = ($urandom_range(0, 7) == 0);
                    send(d[i%3], o[i%3], w);
                    if (i%3 == 2) begin
                        exp_q.push_back(mkvec(exp_elem(d[0], o[0]), exp_elem(d[1], o[1]),
                                              exp_elem(d[2], o[2]), {o[2], o[1], o[0]}));
                        if (o[0] || o[1] || o[2]) nov++;
                    end
                end
                idle();
                done = 1'b1;
            end
            begin
                while (!done) begin
                    bus.m_ready = 1'($urandom_range(0, 1));
                    @(posedge clk); #1;
                end
                bus.m_ready = 1'b1;
            end
        join
        cycles(20);
        checks++;
        if (bus.ovf_count !== 8'(nov)) begin errors++; $display("FAIL rnd_ovf_count: got %0d required %0d", bus.ovf_count, nov); end
        checks++;
        if (got.size() - base != 50) begin
            errors++; $display("FAIL rnd_count: got %0d vectors required 50", got.size() - base);
        end else begin
            for (int j = 0; j < 50; j++) begin
                checks++;
                if (got[base+j] !== exp_q[j]) begin
                    errors++; $display("FAIL rnd_vec%0d: got %h required %h", j, got[base+j], exp_q[j]);
                end
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        bus.m_ready = 1'b0;
        bus.s_valid = 1'b0;
        bus.data_in = 'x;
        bus.ovf_in  = 1'bx;
        test_reset();
        test_basic();
        test_saturation();
        test_backpressure();
        test_throughput();
        test_mid_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
